// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory store buffer.
// The entry index is kept at full word-address width so any DEPTH up to 2^30 fits.
package dmem_pkg;

  localparam int DEPTH_DEF     = 64;
  localparam int SB_DEPTH_DEF  = 4;
  localparam int WR_CYCLES_DEF = 3;
  localparam int IDX_W_MAX     = 30;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic [31:0]          data;
  } sb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store-buffer FIFO with head/tail/count, exposing every slot
// in age order (slot 0 = oldest = head) for the load-forwarding search.
module store_fifo
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_push,
  input  logic [IDX_W_MAX-1:0]              i_idx,
  input  logic [31:0]                       i_data,
  input  logic                              i_pop,
  output logic [SB_DEPTH*IDX_W_MAX-1:0]     o_idx,
  output logic [SB_DEPTH*32-1:0]            o_data,
  output logic [SB_DEPTH-1:0]               o_valid,
  output logic [$clog2(SB_DEPTH+1)-1:0]     o_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH+1);

  sb_entry_t          r_buf [SB_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; validity comes solely from the count.
  always_ff @(posedge clk) begin
    if (i_push) r_buf[r_tail] <= '{idx: i_idx, data: i_data};
  end

  for (genvar k = 0; k < SB_DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] w_slot;
    assign w_slot                         = r_head + PTR_W'(k);
    assign o_idx[k*IDX_W_MAX +: IDX_W_MAX] = r_buf[w_slot].idx;
    assign o_data[k*32 +: 32]             = r_buf[w_slot].data;
    assign o_valid[k]                     = (CNT_W'(k) < r_count);
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder for the MIPS memory stage: posted stores drain
// through a FIFO into a slow backing array; loads forward youngest-first.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int SB_DEPTH  = SB_DEPTH_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rd,
  output logic        stall,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH+1);
  localparam int WC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [WC_W-1:0] WC_RELOAD = WC_W'(WR_CYCLES-1);

  logic [31:0]                    r_mem [DEPTH];
  drain_state_t                   r_state;
  drain_state_t                   w_state_nxt;
  logic [WC_W-1:0]                r_cnt;
  logic [WC_W-1:0]                w_cnt_nxt;

  logic [IDX_W-1:0]               w_idx;
  logic [IDX_W_MAX-1:0]           w_idx_ext;
  logic [SB_DEPTH*IDX_W_MAX-1:0]  w_ent_idx;
  logic [SB_DEPTH*32-1:0]         w_ent_data;
  logic [SB_DEPTH-1:0]            w_valid;
  logic [CNT_W-1:0]               w_count;
  logic                           w_commit;
  logic                           w_push;
  logic                           w_more;
  logic                           w_unused;

  assign w_idx     = a[IDX_W+1:2];
  assign w_idx_ext = {{(IDX_W_MAX-IDX_W){1'b0}}, w_idx};
  assign w_unused  = &{1'b0, re, a[31:IDX_W+2], a[1:0]};

  assign w_commit = (r_state == WRITE) && (r_cnt == '0);
  assign stall    = we && (w_count == CNT_W'(SB_DEPTH)) && !w_commit;
  assign w_push   = we && !stall;
  assign busy     = (w_count != '0) || (r_state != IDLE);
  // Entries left after this edge's pop (plus any push) decide whether draining continues.
  assign w_more   = (w_count > CNT_W'(1)) || w_push;

  store_fifo #(.SB_DEPTH(SB_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_idx   (w_idx_ext),
    .i_data  (wd),
    .i_pop   (w_commit),
    .o_idx   (w_ent_idx),
    .o_data  (w_ent_data),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_state_nxt = WRITE;
          w_cnt_nxt   = WC_RELOAD;
        end
      end
      WRITE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WC_W'(1);
        end else if (w_more) begin
          w_cnt_nxt = WC_RELOAD;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The head (age slot 0) is written on its commit edge; a reset edge discards it.
  always_ff @(posedge clk) begin
    if (w_commit && !reset) r_mem[w_ent_idx[IDX_W-1:0]] <= w_ent_data[31:0];
  end

  // Scan oldest to youngest so the youngest matching entry is the last to win.
  always_comb begin
    rd = r_mem[w_idx];
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (w_valid[k] && (w_ent_idx[k*IDX_W_MAX +: IDX_W_MAX] == w_idx_ext))
        rd = w_ent_data[k*32 +: 32];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench: directed vector tables, hand-written stall/reset
// sequences, and random traffic against a queue-based reference model.
module tb_dmem_store_buffer;

  localparam int DEPTH = 64;
  localparam int SB    = 4;
  localparam int WR    = 3;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic        re;
  logic [31:0] rd;
  logic        stall;
  logic        busy;

  dmem_store_buffer #(.DEPTH(DEPTH), .SB_DEPTH(SB), .WR_CYCLES(WR)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .wd    (wd),
    .we    (we),
    .re    (re),
    .rd    (rd),
    .stall (stall),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Reference model: pending stores in program order, array image, drain timer.
  typedef struct {
    int          idx;
    logic [31:0] data;
  } mentry_t;

  mentry_t     m_q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_active = 0;
  int          m_left   = 0;
  bit          m_chk    = 0;

  task automatic cycle(input logic t_we, input logic [31:0] t_a, input logic [31:0] t_wd,
                       input logic t_re, input logic t_rst,
                       output logic o_stall, output logic o_busy, output logic [31:0] o_rd);
    int          idx;
    bit          commit;
    bit          exp_stall;
    bit          exp_busy;
    bit          rd_known;
    logic [31:0] exp_rd;
    int          n_pre;
    we = t_we; a = t_a; wd = t_wd; re = t_re; reset = t_rst;
    #1;
    o_stall = stall; o_busy = busy; o_rd = rd;
    idx       = int'(t_a[7:2]);
    commit    = m_active && (m_left == 1);
    exp_stall = t_we && (m_q.size() == SB) && !commit;
    exp_busy  = (m_q.size() != 0) || m_active;
    rd_known  = m_known[idx];
    exp_rd    = m_mem[idx];
    foreach (m_q[j]) if (m_q[j].idx == idx) begin
      exp_rd   = m_q[j].data;
      rd_known = 1;
    end
    if (m_chk) begin
      check("model_stall", o_stall, exp_stall);
      check("model_busy", o_busy, exp_busy);
      if (!t_we && rd_known) check($sformatf("model_rd[%0d]", idx), o_rd, exp_rd);
    end
    @(posedge clk);
    n_pre = m_q.size();
    if (t_rst) begin
      m_q.delete();
      m_active = 0;
      m_left   = 0;
    end else begin
      if (commit) begin
        m_mem[m_q[0].idx]   = m_q[0].data;
        m_known[m_q[0].idx] = 1;
        void'(m_q.pop_front());
      end
      if (t_we && !exp_stall) m_q.push_back('{idx: idx, data: t_wd});
      if (commit) begin
        if (m_q.size() > 0) m_left = WR;
        else m_active = 0;
      end else if (m_active) begin
        m_left--;
      end else if (n_pre > 0) begin
        m_active = 1;
        m_left   = WR;
      end
    end
    @(negedge clk);
  endtask

  logic        s_st;
  logic        s_bz;
  logic [31:0] s_rd;
  int          n_cyc;
  int          n_stall;

  task automatic send_store(input logic [31:0] t_a, input logic [31:0] t_wd);
    logic st;
    logic bz;
    logic [31:0] r;
    st = 1;
    for (int k = 0; k < 40 && st; k++) begin
      cycle(1'b1, t_a, t_wd, 1'b0, 1'b0, st, bz, r);
      n_cyc++;
      if (st) n_stall++;
    end
    check("store_accept_timeout", st, 1'b0);
  endtask

  task automatic drain();
    logic st;
    logic bz;
    logic [31:0] r;
    bz = 1;
    for (int k = 0; k < 80 && bz; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, st, bz, r);
    check("drain_timeout", bz, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rst;
    logic        chk_rd;
    logic        exp_stall;
    logic        exp_busy;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v_we, input logic [31:0] v_a, input logic [31:0] v_wd,
                     input logic v_rst, input logic v_chk, input logic v_st,
                     input logic v_bz, input logic [31:0] v_rd);
    vecs.push_back('{we: v_we, a: v_a, wd: v_wd, rst: v_rst, chk_rd: v_chk,
                     exp_stall: v_st, exp_busy: v_bz, exp_rd: v_rd});
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cycle(vecs[i].we, vecs[i].a, vecs[i].wd, !vecs[i].we, vecs[i].rst, s_st, s_bz, s_rd);
      check($sformatf("vec%0d_stall", i), s_st, vecs[i].exp_stall);
      check($sformatf("vec%0d_busy", i), s_bz, vecs[i].exp_busy);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), s_rd, vecs[i].exp_rd);
    end
  endtask

  function automatic logic [31:0] pre_val(input int i);
    return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h101;
  endfunction

  initial begin
    foreach (m_known[i]) m_known[i] = 0;
    we = 0; re = 0; a = '0; wd = '0; reset = 1;

    // Directed table, part A: forwarding, drain latency, same-address ordering.
    add(0, 32'h14, 0, 0, 1, 0, 0, 32'hDEADBEEF);
    add(1, 32'h20, 32'h11111111, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 32'h20, 0, 0, 1, 0, 1, 32'h11111111);
    add(0, 32'h20, 0, 0, 1, 0, 0, 32'h11111111);
    add(1, 32'h40, 32'hA, 0, 0, 0, 0, 0);
    add(1, 32'h40, 32'hB, 0, 0, 0, 1, 0);
    add(1, 32'h40, 32'hC, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 32'h40, 0, 0, 1, 0, 1, 32'hC);
    add(0, 32'h40, 0, 0, 1, 0, 0, 32'hC);
    // Part B: reset asserted on the second WRITE cycle of a drain.
    add(1, 32'h0, 32'hAAAA0000, 0, 0, 0, 0, 0);
    add(1, 32'h4, 32'hBBBB0001, 0, 0, 0, 1, 0);
    add(0, 32'h0, 0, 0, 0, 0, 1, 0);
    add(0, 32'h0, 0, 1, 0, 0, 1, 0);
    add(0, 32'h0, 0, 0, 1, 0, 0, 32'h1000_0000);
    add(0, 32'h4, 0, 0, 1, 0, 0, 32'h1000_0101);

    @(negedge clk);
    cycle(0, 0, 0, 0, 1, s_st, s_bz, s_rd);
    cycle(0, 0, 0, 0, 1, s_st, s_bz, s_rd);
    m_chk = 1;
    cycle(0, 0, 0, 1, 0, s_st, s_bz, s_rd);
    check("reset_stall", s_st, 1'b0);
    check("reset_busy", s_bz, 1'b0);

    for (int i = 0; i < 16; i++) send_store(32'(i) << 2, pre_val(i));
    drain();

    run_vecs(0, 18);

    // Six back-to-back stores: 2 stall cycles, the 5th rides a full-buffer commit.
    n_cyc = 0; n_stall = 0;
    for (int i = 0; i < 6; i++) send_store(32'h80 + 32'(i) * 4, 32'hF00D0000 + 32'(i));
    check("full_cycles", n_cyc, 8);
    check("full_stalls", n_stall, 2);
    drain();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 32'h80 + 32'(i) * 4, 0, 1, 0, s_st, s_bz, s_rd);
      check($sformatf("full_word%0d", i), s_rd, 32'hF00D0000 + 32'(i));
    end

    run_vecs(19, 24);

    // Random traffic over words 0..15 with random upper/low address bits.
    for (int n = 0; n < 400; n++) begin
      logic        r_we;
      logic        r_rst;
      logic [31:0] r_a;
      r_rst = ($urandom_range(0, 63) == 0);
      r_we  = 1'($urandom_range(0, 1));
      r_a   = ($urandom() & 32'hFFFF_FF03) | (32'($urandom_range(0, 15)) << 2);
      cycle(r_we, r_a, $urandom(), 1'($urandom_range(0, 1)), r_rst, s_st, s_bz, s_rd);
    end
    drain();
    for (int i = 0; i < 16; i++) cycle(0, 32'(i) << 2, 0, 1, 0, s_st, s_bz, s_rd);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
